// File: rtl/sdt_mem_resp.sv
// SDT memory responder: a small word-addressed memory behind a rd/wr/ack
// handshake with programmable response latency. It also flags protocol
// misuse (sticky) and counts completed accesses.
module sdt_mem_resp #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int WAIT_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m_rd,
    input  logic                  m_wr,
    input  logic [ADDR_WIDTH-1:0] m_addr,
    input  logic [DATA_WIDTH-1:0] m_wr_data,
    output logic [DATA_WIDTH-1:0] m_rd_data,
    output logic                  m_ack,
    input  logic [WAIT_WIDTH-1:0] wait_cycles,
    input  logic                  err_clr,
    output logic                  busy,
    output logic                  proto_err,
    output logic [15:0]           access_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [WAIT_WIDTH-1:0] WAIT_ONE = {{(WAIT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [WAIT_WIDTH-1:0]   wait_reg, wait_next;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic                    wr_reg;
    logic                    proto_err_reg;
    logic [15:0]             access_cnt_reg;
    logic                    capture;
    logic                    err_set;
    logic                    mem_we;

    // Register array rather than block RAM: reset must clear every word.
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Next-state logic: capture in IDLE, count down in WAIT, abort if the
    // initiator drops its request mid-wait, single-cycle ACK.
    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        capture    = 1'b0;
        err_set    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (m_rd || m_wr) begin
                    capture    = 1'b1;
                    wait_next  = wait_cycles;
                    err_set    = m_rd && m_wr;
                    state_next = (wait_cycles == '0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!(m_rd || m_wr)) begin
                    state_next = IDLE;
                    wait_next  = '0;
                    err_set    = 1'b1;
                end else begin
                    wait_next = wait_reg - WAIT_ONE;
                    if (wait_reg == WAIT_ONE) begin
                        state_next = ACK;
                    end
                end
            end
            ACK: begin
                state_next = IDLE;
                wait_next  = '0;
            end
            default: begin
                state_next = IDLE;
                wait_next  = '0;
            end
        endcase
    end

    // State, wait counter and captured request fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            wait_reg  <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            wr_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            if (capture) begin
                addr_reg <= m_addr;
                data_reg <= m_wr_data;
                wr_reg   <= m_wr;
            end
        end
    end

    // Sticky protocol error; a coincident set beats err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err_reg <= 1'b0;
        end else if (err_set) begin
            proto_err_reg <= 1'b1;
        end else if (err_clr) begin
            proto_err_reg <= 1'b0;
        end
    end

    // Saturating count of completed (acknowledged) accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            access_cnt_reg <= '0;
        end else if (state_reg == ACK && access_cnt_reg != 16'hFFFF) begin
            access_cnt_reg <= access_cnt_reg + 16'd1;
        end
    end

    // Writes commit on the edge that ends ACK, so aborted accesses never land.
    assign mem_we = (state_reg == ACK) && wr_reg;

    // Memory storage, cleared word by word on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[addr_reg] <= data_reg;
        end
    end

    assign m_ack      = (state_reg == ACK);
    assign m_rd_data  = (state_reg == ACK && !wr_reg) ? mem[addr_reg] : '0;
    assign busy       = (state_reg != IDLE);
    assign proto_err  = proto_err_reg;
    assign access_cnt = access_cnt_reg;

endmodule

// File: tb/tb_sdt_mem_resp.sv
// Bench for sdt_mem_resp: the driver pushes the expected read data and ack
// cycle per access; a negedge monitor pops and compares on every m_ack.
module tb_sdt_mem_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_rd = 1'b0;
    logic        m_wr = 1'b0;
    logic [7:0]  m_addr = 8'h00;
    logic [7:0]  m_wr_data = 8'h00;
    logic [3:0]  wait_cycles = 4'd0;
    logic        err_clr = 1'b0;
    logic [7:0]  m_rd_data;
    logic        m_ack;
    logic        busy;
    logic        proto_err;
    logic [15:0] access_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nb;

    typedef struct {
        logic [7:0] data;
        int         at;
    } exp_t;
    exp_t sb[$];

    sdt_mem_resp #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr),
        .m_wr_data(m_wr_data), .m_rd_data(m_rd_data), .m_ack(m_ack),
        .wait_cycles(wait_cycles), .err_clr(err_clr), .busy(busy),
        .proto_err(proto_err), .access_cnt(access_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every ack is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (m_ack === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack at cycle %0d, required none", cyc);
            end else begin
                e = sb.pop_front();
                $display("ack cycle=%0d rd_data=0x%02h", cyc, m_rd_data);
                check("ack_rd_data", 32'(m_rd_data), 32'(e.data));
                check("ack_cycle", cyc, e.at);
            end
        end else begin
            check("idle_rd_data", 32'(m_rd_data), 32'd0);
        end
    end

    // Issue one access (called at posedge+1 in an IDLE cycle), hold it until
    // m_ack, then release and step into the following IDLE cycle.
    task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [7:0] data, input logic [3:0] w,
                          input logic [7:0] exp_data, input logic chg,
                          input logic [7:0] chg_addr, input logic [3:0] chg_w,
                          output int nbusy);
        bit done;
        m_rd = rd;
        m_wr = wr;
        m_addr = addr;
        m_wr_data = data;
        wait_cycles = w;
        sb.push_back('{exp_data, cyc + 1 + int'(w)});
        nbusy = 0;
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk);
            #1;
            if (busy) nbusy++;
            if (k == 0 && chg) begin
                m_addr = chg_addr;
                wait_cycles = chg_w;
            end
            if (m_ack) done = 1;
        end
        m_rd = 1'b0;
        m_wr = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack in 40 cycles, required ack at addr 0x%02h", addr);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(m_ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        check("rst_access_cnt", 32'(access_cnt), 32'd0);
        check("rst_rd_data", 32'(m_rd_data), 32'd0);
        rst = 1'b0;

        // zero-wait write then read
        access(1'b0, 1'b1, 8'h10, 8'hA5, 4'd0, 8'h00, 1'b0, 8'h00, 4'd0, nb);
        access(1'b1, 1'b0, 8'h10, 8'h00, 4'd0, 8'hA5, 1'b0, 8'h00, 4'd0, nb);
        check("s1_access_cnt", 32'(access_cnt), 32'd2);

        // 3-wait read of never-written address
        access(1'b1, 1'b0, 8'h20, 8'h00, 4'd3, 8'h00, 1'b0, 8'h00, 4'd0, nb);
        check("s2_busy_cycles", nb, 4);
        check("s2_busy_after", 32'(busy), 32'd0);

        // inputs change after capture
        access(1'b0, 1'b1, 8'h05, 8'h33, 4'd2, 8'h00, 1'b1, 8'h06, 4'd0, nb);
        access(1'b1, 1'b0, 8'h05, 8'h00, 4'd0, 8'h33, 1'b0, 8'h00, 4'd0, nb);
        access(1'b1, 1'b0, 8'h06, 8'h00, 4'd0, 8'h00, 1'b0, 8'h00, 4'd0, nb);
        check("s3_access_cnt", 32'(access_cnt), 32'd6);

        // rd and wr together: write plus protocol error
        access(1'b1, 1'b1, 8'h07, 8'h5A, 4'd0, 8'h00, 1'b0, 8'h00, 4'd0, nb);
        check("s4_proto_err_set", 32'(proto_err), 32'd1);
        access(1'b1, 1'b0, 8'h07, 8'h00, 4'd0, 8'h5A, 1'b0, 8'h00, 4'd0, nb);
        check("s4_proto_err_sticky", 32'(proto_err), 32'd1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("s4_proto_err_clr", 32'(proto_err), 32'd0);
        check("s4_access_cnt", 32'(access_cnt), 32'd8);

        // request dropped in second WAIT cycle
        m_rd = 1'b1;
        m_addr = 8'h10;
        wait_cycles = 4'd4;
        @(posedge clk);
        #1;
        check("s5_busy_wait", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        m_rd = 1'b0;
        @(posedge clk);
        #1;
        check("s5_busy_abort", 32'(busy), 32'd0);
        check("s5_proto_err", 32'(proto_err), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("s5_access_cnt", 32'(access_cnt), 32'd8);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;

        // reset in the middle of a waited write
        m_wr = 1'b1;
        m_addr = 8'h01;
        m_wr_data = 8'h77;
        wait_cycles = 4'd2;
        @(posedge clk);
        #1;
        check("s6_busy_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        m_wr = 1'b0;
        #1;
        check("s6_busy_rst", 32'(busy), 32'd0);
        check("s6_cnt_rst", 32'(access_cnt), 32'd0);
        check("s6_ack_rst", 32'(m_ack), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        access(1'b1, 1'b0, 8'h01, 8'h00, 4'd0, 8'h00, 1'b0, 8'h00, 4'd0, nb);
        access(1'b1, 1'b0, 8'h10, 8'h00, 4'd0, 8'h00, 1'b0, 8'h00, 4'd0, nb);
        check("s6_access_cnt", 32'(access_cnt), 32'd2);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
